// File: rtl/fm_pkg.sv
// Shared types and constants for the FM frequency discriminator and its
// sequential divider.
package fm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DIV,
    DONE
  } state_t;

  localparam int              QFRAC     = 7;
  localparam logic signed [7:0] XMAX    = 8'sd127;
  localparam logic signed [7:0] XMIN    = 8'sh80;
  localparam int              DIV_STEPS = 7;

endpackage

// File: rtl/fm_demod_if.sv
// Sample-in / message-out bundle for fm_demod. The master side supplies phase
// words and scaling words; the slave side returns the recovered message.
interface fm_demod_if #(
  parameter int W = 32
) ();

  logic [W-1:0]       phase_in;
  logic               phase_valid;
  logic [W-1:0]       kc;
  logic [W-1:0]       k_max;
  logic signed [7:0]  x_out;
  logic               x_valid;
  logic               busy;
  logic               overrun;
  logic               div_err;

  modport master (
    output phase_in, phase_valid, kc, k_max,
    input  x_out, x_valid, busy, overrun, div_err
  );

  modport slave (
    input  phase_in, phase_valid, kc, k_max,
    output x_out, x_valid, busy, overrun, div_err
  );

endinterface

// File: rtl/fm_div_seq.sv
// Restoring divider producing QFRAC fractional quotient bits of mag/kmax,
// one bit per cycle; valid only when mag < kmax.
module fm_div_seq
  import fm_pkg::*;
#(
  parameter int W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [W-1:0]     mag,
  input  logic [W-1:0]     kmax,
  output logic [QFRAC-1:0] q,
  output logic             done
);

  // One extra bit keeps the doubled remainder exact when kmax >= 2^(W-1).
  logic [W:0] rem;
  logic [W:0] r2;
  logic [W:0] kmax_x;
  logic       q_bit;
  logic       run;
  logic [2:0] cnt;

  // NOTE: always_comb assigns every output on every path, so no latch is inferred.
  always_comb begin
    kmax_x = {1'b0, kmax};
    r2     = rem << 1;
    q_bit  = (r2 >= kmax_x);
  end

  // High in the cycle of the last step; q holds the full quotient after that edge.
  assign done = run && (cnt == 3'(DIV_STEPS - 1));

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem <= '0;
      q   <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      rem <= {1'b0, mag};
      q   <= '0;
      cnt <= '0;
      run <= 1'b1;
    end else if (run) begin
      rem <= q_bit ? (r2 - kmax_x) : r2;
      q   <= {q[QFRAC-2:0], q_bit};
      cnt <= cnt + 3'd1;
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/fm_demod.sv
// FM discriminator: x = (delta_phase - kc) * 128 / k_max, saturated to Q1.7,
// with constant latency from a sequential restoring divider.
module fm_demod
  import fm_pkg::*;
#(
  parameter int W = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  fm_demod_if.slave bus
);

  state_t            state;
  logic              primed;
  logic [W-1:0]      phase_prev;
  logic [W-1:0]      dev_r;
  logic [W-1:0]      kmax_r;
  logic              sign_r, sat_r, zero_r;
  logic [W-1:0]      dev_next;
  logic [W-1:0]      mag;
  logic [QFRAC-1:0]  q;
  logic              div_done;
  logic signed [7:0] q_signed;
  logic signed [7:0] x_next;
  logic signed [7:0] x_out_r;
  logic              x_valid_r, busy_r, overrun_r, div_err_r;

  always_comb begin
    dev_next = bus.phase_in - phase_prev - bus.kc;
    // Unsigned magnitude, so the most negative deviation maps to 2^(W-1).
    mag      = dev_r[W-1] ? -dev_r : dev_r;
    q_signed = {1'b0, q};
    x_next   = sign_r ? -q_signed : q_signed;
    if (zero_r)     x_next = '0;
    else if (sat_r) x_next = sign_r ? XMIN : XMAX;
  end

  fm_div_seq #(.W(W)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .start (state == CALC),
    .mag   (mag),
    .kmax  (kmax_r),
    .q     (q),
    .done  (div_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      primed     <= 1'b0;
      phase_prev <= '0;
      dev_r      <= '0;
      kmax_r     <= '0;
      sign_r     <= 1'b0;
      sat_r      <= 1'b0;
      zero_r     <= 1'b0;
      x_out_r    <= '0;
      x_valid_r  <= 1'b0;
      busy_r     <= 1'b0;
      overrun_r  <= 1'b0;
      div_err_r  <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low each cycle and are raised only by the branch that fires.
      x_valid_r <= 1'b0;
      overrun_r <= 1'b0;
      div_err_r <= 1'b0;

      if (bus.phase_valid) begin
        phase_prev <= bus.phase_in;
        primed     <= 1'b1;
        if (primed && state != IDLE) overrun_r <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (bus.phase_valid && primed) begin
            dev_r  <= dev_next;
            kmax_r <= bus.k_max;
            busy_r <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          sign_r <= dev_r[W-1];
          sat_r  <= (mag >= kmax_r);
          zero_r <= (kmax_r == '0);
          state  <= DIV;
        end
        DIV: begin
          if (div_done) state <= DONE;
        end
        DONE: begin
          x_out_r   <= x_next;
          x_valid_r <= 1'b1;
          div_err_r <= zero_r;
          busy_r    <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.x_out   = x_out_r;
  assign bus.x_valid = x_valid_r;
  assign bus.busy    = busy_r;
  assign bus.overrun = overrun_r;
  assign bus.div_err = div_err_r;

endmodule

// File: tb/tb_fm_demod.sv
// Directed bench for fm_demod: an arithmetic reference model checked every cycle,
// plus hand-computed expectations for each directed sample.
module tb_fm_demod;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  fm_demod_if #(.W(32)) bus ();

  fm_demod #(.W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  // Reference model: sample bookkeeping and the quotient from plain arithmetic.
  typedef struct {
    int                due;
    logic signed [7:0] x;
    logic              err;
  } exp_t;

  exp_t              q_exp[$];
  bit                primed_m;
  logic [31:0]       prev_m;
  int                free_at;
  int                acc_at;
  bit                ovr_m, busy_m, exp_v_now, exp_err_now;
  logic signed [7:0] hold_x;

  always @(posedge clk) begin
    logic [31:0] dev;
    longint      v;
    exp_t        e;
    cyc++;
    ovr_m     = 1'b0;
    exp_v_now = 1'b0;
    if (!rst_n) begin
      primed_m    = 1'b0;
      prev_m      = '0;
      free_at     = 0;
      acc_at      = -100;
      hold_x      = '0;
      exp_err_now = 1'b0;
      q_exp.delete();
    end else begin
      if (bus.phase_valid) begin
        if (!primed_m) begin
          primed_m = 1'b1;
        end else if (cyc < free_at) begin
          ovr_m = 1'b1;
        end else begin
          dev = bus.phase_in - prev_m - bus.kc;
          if (bus.k_max == 0) begin
            e.x   = '0;
            e.err = 1'b1;
          end else begin
            v = (longint'($signed(dev)) * 128) / longint'(bus.k_max);
            if (v > 127)  v = 127;
            if (v < -128) v = -128;
            e.x   = 8'(v);
            e.err = 1'b0;
          end
          e.due   = cyc + 9;
          q_exp.push_back(e);
          acc_at  = cyc;
          free_at = cyc + 10;
        end
        prev_m = bus.phase_in;
      end
      if (q_exp.size() > 0 && q_exp[0].due == cyc) begin
        exp_v_now   = 1'b1;
        hold_x      = q_exp[0].x;
        exp_err_now = q_exp[0].err;
        void'(q_exp.pop_front());
      end
    end
    busy_m = (cyc >= acc_at) && (cyc < acc_at + 9);
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      check("x_valid", bus.x_valid, exp_v_now);
      check("x_out",   bus.x_out,   hold_x);
      check("div_err", bus.div_err, exp_v_now & exp_err_now);
      check("overrun", bus.overrun, ovr_m);
      check("busy",    bus.busy,    busy_m);
    end
  end

  task automatic send(input logic [31:0] ph, input logic [31:0] kc_v, input logic [31:0] km,
                      output int t0);
    @(negedge clk);
    bus.phase_in    = ph;
    bus.kc          = kc_v;
    bus.k_max       = km;
    bus.phase_valid = 1'b1;
    t0              = cyc;
    @(negedge clk);
    bus.phase_valid = 1'b0;
  endtask

  task automatic expect_result(input string name, input logic signed [7:0] xe,
                               input logic ee, input int t0);
    bit got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.x_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({name, "_seen"}, got, 1);
    if (got) begin
      check({name, "_lat"}, cyc - t0, 10);
      check(name, bus.x_out, xe);
      check({name, "_err"}, bus.div_err, ee);
    end
  endtask

  task automatic expect_quiet(input string name, input int n);
    int seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.x_valid) seen++;
    end
    check(name, seen, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t_first;
    bus.phase_valid = 1'b0;
    bus.phase_in    = '0;
    bus.kc          = '0;
    bus.k_max       = '0;
    rst_n           = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_x_out", bus.x_out, 0);
    check("rst_busy",  bus.busy, 0);
    rst_n = 1'b1;

    // Priming sample only loads the phase history.
    send(32'd0, 32'd1000, 32'd256, t);
    expect_quiet("prime_quiet", 12);

    send(32'd1128, 32'd1000, 32'd256, t);
    expect_result("pos64", 8'sh40, 1'b0, t);
    send(32'd2000, 32'd1000, 32'd256, t);
    expect_result("neg64", 8'shC0, 1'b0, t);
    send(32'd3300, 32'd1000, 32'd256, t);
    expect_result("sat_pos", 8'sh7F, 1'b0, t);
    send(32'd4044, 32'd1000, 32'd256, t);
    expect_result("sat_neg_eq", 8'sh80, 1'b0, t);

    // Wrap of the phase accumulator through 2^32.
    send(32'hFFFF_FF00, 32'd1000, 32'd256, t);
    expect_result("wrap_pre", 8'sh80, 1'b0, t);
    send(32'h0000_0368, 32'd1000, 32'd256, t);
    expect_result("wrap", 8'sh40, 1'b0, t);

    send(32'd1877, 32'd1000, 32'd0, t);
    expect_result("kzero", 8'sh00, 1'b1, t);

    // 100*128/300 = 42.67 truncates toward zero in both signs.
    send(32'd2977, 32'd1000, 32'd300, t);
    expect_result("trunc_pos", 8'sh2A, 1'b0, t);
    send(32'd3877, 32'd1000, 32'd300, t);
    expect_result("trunc_neg", 8'shD6, 1'b0, t);

    // Overrun: second sample 3 cycles after accept is dropped but updates history.
    send(32'd5005, 32'd1000, 32'd256, t_first);
    @(negedge clk);
    send(32'd10005, 32'd1000, 32'd256, t);
    check("overrun_pulse", bus.overrun, 1);
    expect_result("ovr_first", 8'sh40, 1'b0, t_first);
    send(32'd11133, 32'd1000, 32'd256, t);
    expect_result("ovr_next", 8'sh40, 1'b0, t);

    // Reset during the fourth divide step aborts the conversion and unprimes.
    send(32'd12261, 32'd1000, 32'd256, t);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    expect_quiet("rst_abort", 15);
    check("rst_abort_busy", bus.busy, 0);
    send(32'd50000, 32'd1000, 32'd256, t);
    expect_quiet("reprime", 12);
    send(32'd51128, 32'd1000, 32'd256, t);
    expect_result("after_rst", 8'sh40, 1'b0, t);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
